idp20_link_scheduler: RTL
=========================

Name: idp20_link_scheduler

Overview:
- Shares one IDP_encoder_20 / 20-TSV link between NREQ requesters.
- Round-robin arbitration in bursts of up to BURST_MAX words.
- Range-checks each word against the IDP code space, so only encodable values reach the encoder.
- Drives IDLE_WORD for GUARD cycles between grants so the receiver can separate bursts.

Parameters:
- NREQ, 4: number of requesters.
- W, 15: data width; equals `IBLEN20.
- CODE_SPACE, 21892: number of legal IDP-20 input values (0..21891).
- BURST_MAX, 8: maximum words per grant.
- GUARD, 1: idle cycles inserted after each grant ends (0 allowed).
- IDLE_WORD, 0: value driven on enc_data when no valid word is presented.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*W  requester i occupies bits [i*W +: W].
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- err_clr  in  NREQ  write-1-to-clear for err_flag.
- enc_data  out  W  word to the encoder datain, registered.
- enc_valid  out  1  enc_data carries a real word this cycle, registered.
- grant_id  out  clog2(NREQ)  current owner, valid while busy=1.
- busy  out  1  state is SEND or GUARD.
- err_flag  out  NREQ  sticky: requester i sent an out-of-range word.
- err_count  out  16  total out-of-range words, saturating at 16'hFFFF.

Behaviour:
Reset (rst_n low at a rising edge):
- state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, guard_cnt=0.
- enc_data=IDLE_WORD, enc_valid=0, err_flag=0, err_count=0.
- req_ready=0 while in reset and in the first cycle after.
- Reset mid-burst aborts the burst. The word in flight is dropped and is not re-sent.

FSM:
- IDLE
  - If any req_valid is high: grant the first index at or after rr_ptr (cyclic search), register grant_id, burst_cnt=0, go to SEND.
  - Otherwise stay in IDLE.
  - No transfer occurs in IDLE.
- SEND
  - req_ready[grant_id]=1; all other bits 0. req_ready is decoded from registered state only, with no combinational path from req_valid.
  - A transfer happens when req_valid[g] and req_ready[g] are both high; burst_cnt increments.
  - Leave SEND when either:
    - a transfer makes burst_cnt reach BURST_MAX, or
    - req_valid[grant_id] is low (no transfer that cycle).
  - On leaving: rr_ptr = (grant_id+1) mod NREQ; go to GUARD with guard_cnt=GUARD, or go straight to IDLE if GUARD=0.
- GUARD
  - guard_cnt decrements each cycle; go to IDLE when it reaches 1.
  - No request is accepted.

Datapath:
- A transfer in cycle t with data < CODE_SPACE sets enc_data=data and enc_valid=1 in cycle t+1.
- A transfer with data >= CODE_SPACE (unsigned compare over W bits):
  - word is consumed and counts toward burst_cnt;
  - enc_data=IDLE_WORD and enc_valid=0 in cycle t+1;
  - err_flag[g] is set and err_count increments, saturating.
- Every cycle without a transfer drives enc_data=IDLE_WORD and enc_valid=0 in the next cycle.

err_flag:
- err_clr[i] clears bit i.
- If set and clear hit the same bit in the same cycle, set wins.

Latency and throughput:
- Grant to first possible transfer: 1 cycle.
- Accepted word to enc_data: 1 cycle.
- Steady state: one word per cycle within a burst.
- Between two bursts: exactly GUARD+1 cycles with enc_valid=0 (GUARD idle cycles plus the IDLE arbitration cycle).

Boundaries:
- A sole active requester is regranted after guard and arbitration.
- Value CODE_SPACE-1 is legal; value CODE_SPACE is illegal.
- err_count holds at 16'hFFFF once saturated.
- A requester dropping valid mid-burst releases the grant immediately.

Test Plan:
1. Reset, then req_valid=4'b0001, req_data[0]=356 held for 3 cycles and dropped.
   - enc_data=356 with enc_valid=1 for 3 cycles, starting 2 cycles after req_valid rises.
   - Then 1 guard cycle and idle; grant_id=0.
2. All four requesters valid continuously, BURST_MAX=8, GUARD=1.
   - Grants go 0,1,2,3,0, with 8 words each.
   - Exactly 2 enc_valid=0 cycles between bursts.
   - req_ready is never more than one-hot.
3. Requester 2 sends 21891, then 21892, then 32767.
   - 21891 reaches enc_data.
   - The other two give enc_valid=0 with enc_data=0.
   - err_flag=4'b0100, err_count=2.
   - err_clr[2] pulse returns err_flag to 0; err_count unchanged.
4. Set/clear collision: err_clr[1]=1 in the same cycle an illegal word from requester 1 transfers -> err_flag[1]=1 afterwards.
5. rst_n low for 1 cycle during the 4th word of a burst from requester 3.
   - Next cycle: enc_valid=0, busy=0, rr_ptr=0.
   - With all requesters valid, the next grant goes to requester 0.
6. Random legal words, 100000 cycles, random valid patterns, driving IDP_encoder_20 into IDP_dec_20.
   - Decoded output matches the enc_valid words in order.
   - No 101 or 010 pattern on any 3 adjacent TSVs.
   - err_count=0.

Source files
------------

// File: rtl/idp20_link_scheduler.sv
// rtl/idp20_link_scheduler.sv - round-robin burst scheduler sharing one IDP-20 encoder link
// Range-checks every granted word against the IDP code space and inserts guard idles between bursts.
module idp20_link_scheduler #(
    parameter int NREQ       = 4,
    parameter int W          = 15,
    parameter int CODE_SPACE = 21892,
    parameter int BURST_MAX  = 8,
    parameter int GUARD      = 1,
    parameter int IDLE_WORD  = 0,
    localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   err_clr,
    output logic [W-1:0]      enc_data,
    output logic              enc_valid,
    output logic [IW-1:0]     grant_id,
    output logic              busy,
    output logic [NREQ-1:0]   err_flag,
    output logic [15:0]       err_count
);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GUARD} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic [W-1:0]    enc_data_q, enc_data_d;
    logic            enc_valid_q, enc_valid_d;
    logic [NREQ-1:0] err_flag_q, err_flag_d;
    logic [15:0]     err_count_q, err_count_d;
    logic [W-1:0]    word;
    logic [IW-1:0]   idx;
    logic            found;
    logic            release_grant;

    assign word = req_data[int'(grant_q)*W +: W];

    // Ready depends only on registered state, never on req_valid.
    always_comb begin
        req_ready = '0;
        if (state_q == S_SEND) req_ready[grant_q] = 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        burst_d       = burst_q;
        guard_d       = guard_q;
        enc_data_d    = W'(IDLE_WORD);
        enc_valid_d   = 1'b0;
        err_flag_d    = err_flag_q & ~err_clr;
        err_count_d   = err_count_q;
        found         = 1'b0;
        idx           = '0;
        release_grant = 1'b0;
        case (state_q)
            S_IDLE: begin
                for (int i = 0; i < NREQ; i++) begin
                    idx = IW'((int'(rr_ptr_q) + i) % NREQ);
                    if (!found && req_valid[idx]) begin
                        found   = 1'b1;
                        grant_d = idx;
                    end
                end
                if (found) begin
                    burst_d = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (req_valid[grant_q]) begin
                    burst_d = burst_q + 1'b1;
                    if ({1'b0, word} < (W+1)'(CODE_SPACE)) begin
                        enc_data_d  = word;
                        enc_valid_d = 1'b1;
                    end else begin
                        // Set is applied after clear so a colliding clear loses.
                        err_flag_d[grant_q] = 1'b1;
                        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 1'b1;
                    end
                    if (burst_q == BW'(BURST_MAX - 1)) release_grant = 1'b1;
                end else begin
                    release_grant = 1'b1;
                end
                if (release_grant) begin
                    rr_ptr_d = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                    guard_d  = GW'(GUARD);
                    state_d  = (GUARD == 0) ? S_IDLE : S_GUARD;
                end
            end
            S_GUARD: begin
                guard_d = guard_q - 1'b1;
                if (guard_q <= GW'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_q     <= '0;
            guard_q     <= '0;
            enc_data_q  <= W'(IDLE_WORD);
            enc_valid_q <= 1'b0;
            err_flag_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_q     <= burst_d;
            guard_q     <= guard_d;
            enc_data_q  <= enc_data_d;
            enc_valid_q <= enc_valid_d;
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
        end
    end

    assign enc_data  = enc_data_q;
    assign enc_valid = enc_valid_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != S_IDLE);
    assign err_flag  = err_flag_q;
    assign err_count = err_count_q;
endmodule
